// File: rtl/rndgen_pkg.sv
// xapp052 XNOR-LFSR tap sets, shared feedback function and scheduler state type.
package rndgen_pkg;

  localparam int RNDGEN_MAX_T = 64;

  // Tap positions are 1-based bit numbers; a zero entry means an unused tap slot.
  typedef struct packed {
    logic [6:0]      TapeNum;
    logic [3:0][6:0] FB;
  } RndGenParams_t;

  localparam RndGenParams_t RndGen8  = '{TapeNum: 7'd8,  FB: {7'd4,  7'd5,  7'd6,  7'd8}};
  localparam RndGenParams_t RndGen16 = '{TapeNum: 7'd16, FB: {7'd4,  7'd13, 7'd15, 7'd16}};
  localparam RndGenParams_t RndGen31 = '{TapeNum: 7'd31, FB: {7'd0,  7'd0,  7'd28, 7'd31}};
  localparam RndGenParams_t RndGen32 = '{TapeNum: 7'd32, FB: {7'd1,  7'd2,  7'd22, 7'd32}};
  localparam RndGenParams_t RndGen64 = '{TapeNum: 7'd64, FB: {7'd60, 7'd61, 7'd63, 7'd64}};

  typedef enum logic [1:0] {IDLE, SHIFT, PRESENT} RndGenSchedState_t;

  function automatic logic rndgen_fb(RndGenParams_t p, logic [RNDGEN_MAX_T-1:0] s);
    logic       acc;
    logic [6:0] tap;
    acc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tap = p.FB[k] - 7'd1;
      if (p.FB[k] != 7'd0) acc = acc ^ s[tap[5:0]];
    end
    return ~acc;
  endfunction

endpackage

// File: rtl/rndgen_lfsr.sv
// T-bit XNOR LFSR: seed load (all-ones maps to 0) has priority over a single step per cycle.
// With RNDGEN_LOCKUP_DET_EN an all-ones state is replaced by 0 next cycle and flagged on sticky lockup_o.
module rndgen_lfsr
  import rndgen_pkg::*;
#(
  parameter RndGenParams_t PARAMS = RndGen31,
  localparam int T = int'(PARAMS.TapeNum)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [T-1:0] seed_i,
  input  logic         step_i,
`ifdef RNDGEN_LOCKUP_DET_EN
  output logic         lockup_o,
`endif
  output logic         fb_o
);

  logic [T-1:0] lfsr_q, lfsr_d;

  assign fb_o = rndgen_fb(PARAMS, RNDGEN_MAX_T'(lfsr_q));

`ifdef RNDGEN_LOCKUP_DET_EN
  logic lockup_q, lockup_d;
  assign lockup_o = lockup_q;
`endif

  always_comb begin
    lfsr_d = lfsr_q;
`ifdef RNDGEN_LOCKUP_DET_EN
    lockup_d = lockup_q;
`endif
    if (load_i) begin
      lfsr_d = (&seed_i) ? '0 : seed_i;
`ifdef RNDGEN_LOCKUP_DET_EN
      lockup_d = 1'b0;
    end else if (&lfsr_q) begin
      lfsr_d   = '0;
      lockup_d = 1'b1;
`endif
    end else if (step_i) begin
      lfsr_d = {lfsr_q[T-2:0], fb_o};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_q <= '0;
`ifdef RNDGEN_LOCKUP_DET_EN
      lockup_q <= 1'b0;
`endif
    end else begin
      lfsr_q <= lfsr_d;
`ifdef RNDGEN_LOCKUP_DET_EN
      lockup_q <= lockup_d;
`endif
    end
  end

endmodule

// File: rtl/rndgen_sched.sv
// Round-robin scheduler sharing one XNOR LFSR; rsp_valid rises OUT_W+1 cycles after req, word held under backpressure.
// Optional RNDGEN_LOCKUP_DET_EN adds lock-up recovery and the sticky lockup_o port.
module rndgen_sched
  import rndgen_pkg::*;
#(
  parameter RndGenParams_t PARAMS = RndGen31,
  parameter int N_REQ = 4,
  parameter int OUT_W = 16,
  localparam int T   = int'(PARAMS.TapeNum),
  localparam int IDW = $clog2(N_REQ),
  localparam int CW  = $clog2(OUT_W + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [OUT_W-1:0] rsp_data_o,
  output logic [IDW-1:0]   rsp_id_o,
  input  logic             seed_we_i,
  input  logic [T-1:0]     seed_i,
`ifdef RNDGEN_LOCKUP_DET_EN
  output logic             lockup_o,
`endif
  output logic             busy_o
);

  RndGenSchedState_t state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d, id_q, id_d, win_id;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  sh_q, sh_d;
  logic              win_vld, step, fb;
  int                cand;

  rndgen_lfsr #(.PARAMS(PARAMS)) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (seed_we_i),
    .seed_i  (seed_i),
    .step_i  (step),
`ifdef RNDGEN_LOCKUP_DET_EN
    .lockup_o(lockup_o),
`endif
    .fb_o    (fb)
  );

  // First requester at or after rr_q, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = rr_q;
    cand    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && req_i[IDW'(cand)]) begin
        win_vld = 1'b1;
        win_id  = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    step    = 1'b0;
    gnt_o   = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A seed write abandons the partial word; the request stays pending for re-arbitration.
        if (seed_we_i) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          sh_d  = OUT_W'({sh_q, fb});
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(OUT_W - 1)) state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (rsp_ready_i) begin
          gnt_o[id_q] = 1'b1;
          rr_d        = (int'(id_q) == N_REQ - 1) ? '0 : id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  assign rsp_valid_o = (state_q == PRESENT);
  assign rsp_data_o  = sh_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);

endmodule
